amo_initiator: RTL and testbench
================================

AMO_INITIATOR -- requirements
Module: amo_initiator

Interface
REQ-001 SHALL have parameter AddrMemWidth, default 32: bank word-address width.
REQ-002 SHALL have parameter DataWidth, default 64: bank data width; only 32 or 64 legal.
REQ-003 SHALL have clk_i  in  1  clock.
REQ-004 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have req_valid_i  in  1  core request valid.
REQ-006 SHALL have req_ready_o  out  1  core request accepted.
REQ-007 SHALL have req_addr_i  in  AddrMemWidth+log2(DataWidth/8)  byte address.
REQ-008 SHALL have req_amo_i  in  4  AMO opcode (0x0 none … 0xA CAS).
REQ-009 SHALL have req_wen_i  in  1  1 store, 0 load; ignored when amo != 0.
REQ-010 SHALL have req_wdata_i  in  32  store data / AMO operand / CAS compare value.
REQ-011 SHALL have req_swap_i  in  32  CAS new value.
REQ-012 SHALL have req_be_i  in  4  store byte enables.
REQ-013 SHALL have rsp_valid_o  out  1; rsp_ready_i  in  1; rsp_rdata_o  out  32; rsp_err_o  out  1.
REQ-014 SHALL have bank side out_req_o, in_gnt_i, out_add_o [AddrMemWidth], out_amo_o [4], out_wen_o, out_wdata_o [DataWidth], out_be_o [DataWidth/8], in_rdata_i [DataWidth].

Function
REQ-015 SHALL implement FSM IDLE -> REQ -> WAIT_R -> RESP -> IDLE, one transaction outstanding.
REQ-016 SHALL assert req_ready_o in IDLE, or in RESP when rsp_ready_i=1; acceptance registers all request fields and enters REQ.
REQ-017 SHALL drive out_req_o=1 only in REQ, holding all bank outputs stable until in_gnt_i=1, then enter WAIT_R.
REQ-018 SHALL set out_add_o = addr[MSB:log2(DataWidth/8)]; word select = addr[2] (64-bit only, else 0).
REQ-019 64-bit lower word: out_wdata_o={swap,wdata} for CAS else {32'b0,wdata}; out_be_o={4'b0,be}.
REQ-020 64-bit upper word: out_wdata_o={wdata,32'b0}; out_be_o={be,4'b0}.
REQ-021 For loads and every AMO, be SHALL be forced to 4'b1111 in selected half; out_wen_o=0 for AMOs.
REQ-022 In WAIT_R SHALL capture selected 32-bit half of in_rdata_i into rsp_rdata_o (stores capture 0), enter RESP.
REQ-023 rsp_valid_o=1 exactly in RESP; data stable until rsp_ready_i=1.
REQ-024 Minimum latency: accept cycle 0, grant cycle 1, rsp_valid_o cycle 3; back-to-back accept in RESP handshake cycle.
REQ-025 Grant withheld (bank busy committing an AMO) SHALL only extend REQ; no request re-issue or field change.

Reset
REQ-026 Asynchronous reset SHALL force IDLE; out_req_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, all other registered outputs 0.
REQ-027 Reset mid-transaction SHALL abandon it silently; no response produced after release.

Configuration
REQ-028 Macro AMO_INITIATOR_CHECK_EN defined: opcode 0xB–0xF, or CAS with DataWidth=32 or addr[2]=1, SHALL skip bank access, go IDLE->RESP next cycle with rsp_err_o=1, rsp_rdata_o=0.
REQ-029 Macro undefined: all requests forwarded unchecked; rsp_err_o tied 0.

Structure
REQ-030 amo_op_t enum (codes 0x0–0xA) SHALL live in shared package amo_pkg, used also by the bank-side AMO shim.
REQ-031 Combinational packing (REQ-018..021) SHALL be sub-module amo_req_pack; FSM and response register stay in top.

Verification
REQ-032 Load 64-bit, addr=0x0C, in_rdata_i=0xAAAA_BBBB_CCCC_DDDD -> out_add_o=1, out_be_o=0xF0, rsp_rdata_o=0xAAAA_BBBB.
REQ-033 AMOAdd addr=0x00, wdata=5, in_gnt_i held low 3 cycles -> out_req_o held 4 cycles, out_be_o=0x0F, out_wen_o=0, rsp at cycle 6.
REQ-034 CAS addr=0x08, wdata=0x10, swap=0x20 -> out_wdata_o=0x0000_0020_0000_0010, out_be_o=0x0F, out_amo_o=0xA.
REQ-035 rsp_ready_i low 5 cycles with new req_valid_i -> rsp_rdata_o stable, req_ready_o=0 until handshake, then accept same cycle.
REQ-036 With AMO_INITIATOR_CHECK_EN, amo=0xC -> no out_req_o, rsp_valid_o cycle 1, rsp_err_o=1; without, out_amo_o=0xC issued.
REQ-037 rst_ni low during WAIT_R -> outputs zero immediately, no rsp_valid_o after release.

Source files
------------

// File: rtl/amo_pkg.sv
// Shared AMO opcode encoding for the core-side initiator and the bank-side AMO shim.
// Opcodes above AMO_CAS are reserved and never produced by a well-behaved core.
package amo_pkg;

  typedef enum logic [3:0] {
    AMO_NONE = 4'h0,
    AMO_SWAP = 4'h1,
    AMO_ADD  = 4'h2,
    AMO_AND  = 4'h3,
    AMO_OR   = 4'h4,
    AMO_XOR  = 4'h5,
    AMO_MAX  = 4'h6,
    AMO_MAXU = 4'h7,
    AMO_MIN  = 4'h8,
    AMO_MINU = 4'h9,
    AMO_CAS  = 4'hA
  } amo_op_t;

  function automatic logic amo_is_store(input logic [3:0] amo, input logic wen);
    return (amo == AMO_NONE) && wen;
  endfunction

endpackage

// File: rtl/amo_req_pack.sv
// Packs a registered 32-bit core request onto the 32/64-bit bank word.
// Latency: purely combinational. Backpressure: none, the caller holds inputs stable.
module amo_req_pack
  import amo_pkg::*;
#(
  parameter int unsigned AddrMemWidth = 32,
  parameter int unsigned DataWidth    = 64
) (
  input  logic [AddrMemWidth+$clog2(DataWidth/8)-1:0] addr,
  input  logic [3:0]                                  amo,
  input  logic                                        wen,
  input  logic [31:0]                                 wdata,
  input  logic [31:0]                                 swap,
  input  logic [3:0]                                  be,
  output logic [AddrMemWidth-1:0]                     out_add,
  output logic [3:0]                                  out_amo,
  output logic                                        out_wen,
  output logic [DataWidth-1:0]                        out_wdata,
  output logic [DataWidth/8-1:0]                      out_be,
  output logic                                        word_sel
);

  localparam int unsigned ByteOff = $clog2(DataWidth/8);

  logic       store;
  logic [3:0] be_eff;

  // Loads and AMOs always touch the whole selected 32-bit half.
  assign store   = amo_is_store(amo, wen);
  assign be_eff  = store ? be : 4'hF;
  assign out_add = addr[AddrMemWidth+ByteOff-1:ByteOff];
  assign out_amo = amo;
  assign out_wen = store;

  if (DataWidth == 64) begin : g_dw64
    logic unused_lsb;
    assign unused_lsb = ^addr[1:0];
    assign word_sel   = addr[2];

    always_comb begin
      if (word_sel) begin
        out_wdata = {wdata, 32'h0};
        out_be    = {be_eff, 4'h0};
      end else begin
        out_wdata = (amo == AMO_CAS) ? {swap, wdata} : {32'h0, wdata};
        out_be    = {4'h0, be_eff};
      end
    end
  end else begin : g_dw32
    logic unused_bits;
    assign unused_bits = ^{swap, addr[ByteOff-1:0]};
    assign word_sel    = 1'b0;
    assign out_wdata   = wdata;
    assign out_be      = be_eff;
  end

endmodule

// File: rtl/amo_initiator.sv
// Core-to-bank AMO initiator, one transaction outstanding; define AMO_INITIATOR_CHECK_EN to reject bad opcodes.
// Latency: accept -> response in 3 cycles with immediate grant. Backpressure: grant stretches REQ, rsp_ready stretches RESP.
module amo_initiator
  import amo_pkg::*;
#(
  parameter int unsigned AddrMemWidth = 32,
  parameter int unsigned DataWidth    = 64
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        req_valid_i,
  output logic                                        req_ready_o,
  input  logic [AddrMemWidth+$clog2(DataWidth/8)-1:0] req_addr_i,
  input  logic [3:0]                                  req_amo_i,
  input  logic                                        req_wen_i,
  input  logic [31:0]                                 req_wdata_i,
  input  logic [31:0]                                 req_swap_i,
  input  logic [3:0]                                  req_be_i,
  output logic                                        rsp_valid_o,
  input  logic                                        rsp_ready_i,
  output logic [31:0]                                 rsp_rdata_o,
  output logic                                        rsp_err_o,
  output logic                                        out_req_o,
  input  logic                                        in_gnt_i,
  output logic [AddrMemWidth-1:0]                     out_add_o,
  output logic [3:0]                                  out_amo_o,
  output logic                                        out_wen_o,
  output logic [DataWidth-1:0]                        out_wdata_o,
  output logic [DataWidth/8-1:0]                      out_be_o,
  input  logic [DataWidth-1:0]                        in_rdata_i
);

  localparam int unsigned AW = AddrMemWidth + $clog2(DataWidth/8);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [3:0]  amo_q, be_q;
  logic        wen_q;
  logic [31:0] wdata_q, swap_q, rdata_q, rdata_half;
  logic        accept, illegal, word_sel;

  logic [AddrMemWidth-1:0]  p_add;
  logic [3:0]               p_amo;
  logic                     p_wen;
  logic [DataWidth-1:0]     p_wdata;
  logic [DataWidth/8-1:0]   p_be;

  assign req_ready_o = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;

`ifdef AMO_INITIATOR_CHECK_EN
  logic err_q;
  // Reserved opcodes and CAS on anything but the lower half of a 64-bit word are refused locally.
  assign illegal = (req_amo_i > AMO_CAS) ||
                   ((req_amo_i == AMO_CAS) && ((DataWidth == 32) || req_addr_i[2]));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= illegal;
    end
  end
  assign rsp_err_o = err_q && (state_q == RESP);
`else
  assign illegal   = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = illegal ? RESP : REQ;
    end else begin
      case (state_q)
        REQ:     if (in_gnt_i) state_d = WAIT_R;
        WAIT_R:  state_d = RESP;
        RESP:    if (rsp_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      amo_q   <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      swap_q  <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr_i;
        amo_q   <= req_amo_i;
        wen_q   <= req_wen_i;
        wdata_q <= req_wdata_i;
        swap_q  <= req_swap_i;
        be_q    <= req_be_i;
      end
      if (accept && illegal) begin
        rdata_q <= '0;
      end else if (state_q == WAIT_R) begin
        rdata_q <= p_wen ? 32'h0 : rdata_half;
      end
    end
  end

  amo_req_pack #(
    .AddrMemWidth(AddrMemWidth),
    .DataWidth   (DataWidth)
  ) u_pack (
    .addr     (addr_q),
    .amo      (amo_q),
    .wen      (wen_q),
    .wdata    (wdata_q),
    .swap     (swap_q),
    .be       (be_q),
    .out_add  (p_add),
    .out_amo  (p_amo),
    .out_wen  (p_wen),
    .out_wdata(p_wdata),
    .out_be   (p_be),
    .word_sel (word_sel)
  );

  if (DataWidth == 64) begin : g_rd64
    assign rdata_half = word_sel ? in_rdata_i[DataWidth-1:32] : in_rdata_i[31:0];
  end else begin : g_rd32
    logic unused_sel;
    assign unused_sel = word_sel;
    assign rdata_half = in_rdata_i[31:0];
  end

  // Bank outputs are quiet outside REQ so idle and reset present all-zero to the bank.
  assign out_req_o   = (state_q == REQ);
  assign out_add_o   = out_req_o ? p_add   : '0;
  assign out_amo_o   = out_req_o ? p_amo   : '0;
  assign out_wen_o   = out_req_o && p_wen;
  assign out_wdata_o = out_req_o ? p_wdata : '0;
  assign out_be_o    = out_req_o ? p_be    : '0;

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_amo_initiator.sv
// Bench for amo_initiator: transaction-level model checked every cycle plus directed literal cases.
module tb_amo_initiator;

`ifdef AMO_INITIATOR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [34:0] req_addr_i = '0;
  logic [3:0]  req_amo_i = '0;
  logic        req_wen_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic [31:0] req_swap_i = '0;
  logic [3:0]  req_be_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        out_req_o;
  logic        in_gnt_i = 1'b0;
  logic [31:0] out_add_o;
  logic [3:0]  out_amo_o;
  logic        out_wen_o;
  logic [63:0] out_wdata_o;
  logic [7:0]  out_be_o;
  logic [63:0] in_rdata_i = '0;

  amo_initiator dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_amo_i(req_amo_i), .req_wen_i(req_wen_i),
    .req_wdata_i(req_wdata_i), .req_swap_i(req_swap_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .out_req_o(out_req_o), .in_gnt_i(in_gnt_i), .out_add_o(out_add_o),
    .out_amo_o(out_amo_o), .out_wen_o(out_wen_o), .out_wdata_o(out_wdata_o),
    .out_be_o(out_be_o), .in_rdata_i(in_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_rsp = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected bank word for a request, straight from the packing rules.
  task automatic pack_exp(input logic [34:0] a, input logic [3:0] amo, input logic wen,
                          input logic [31:0] wd, input logic [31:0] sw, input logic [3:0] be,
                          output logic [31:0] add, output logic wen_o,
                          output logic [63:0] wdo, output logic [7:0] beo);
    logic [3:0] bs;
    add   = a[34:3];
    wen_o = (amo == 4'h0) && wen;
    bs    = wen_o ? be : 4'hF;
    if (a[2]) begin
      wdo = {wd, 32'h0};
      beo = {bs, 4'h0};
    end else begin
      wdo = (amo == 4'hA) ? {sw, wd} : {32'h0, wd};
      beo = {4'h0, bs};
    end
  endtask

  function automatic logic illegal_exp(input logic [3:0] amo, input logic [34:0] a);
    return CHECK_EN && ((amo > 4'hA) || ((amo == 4'hA) && a[2]));
  endfunction

  // Model: the one outstanding transaction, when it was granted, and what it must return.
  bit          m_pend = 0, m_gnt = 0, m_err = 0;
  int          m_gcyc = 0;
  logic [34:0] m_addr;
  logic [3:0]  m_amo, m_be;
  logic        m_wen;
  logic [31:0] m_wdata, m_swap, m_rdata;

  always @(negedge clk_i) begin
    logic        e_rsp, e_req, e_rdy, e_wen;
    logic [31:0] e_add;
    logic [63:0] e_wd;
    logic [7:0]  e_be;
    if (!rst_ni) begin
      m_pend = 0; m_gnt = 0; m_err = 0;
      chk("rst_out_req", out_req_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_rsp_err", rsp_err_o, 0);
      chk("rst_rsp_rdata", rsp_rdata_o, 0);
      chk("rst_out_be", out_be_o, 0);
      chk("rst_out_wdata", out_wdata_o, 0);
      chk("rst_out_add", out_add_o, 0);
    end else begin
      if (m_pend && m_gnt && cyc == m_gcyc + 1)
        m_rdata = ((m_amo == 4'h0) && m_wen) ? 32'h0 :
                  (m_addr[2] ? in_rdata_i[63:32] : in_rdata_i[31:0]);
      e_rsp = m_pend && (m_err || (m_gnt && cyc >= m_gcyc + 2));
      e_req = m_pend && !m_err && !m_gnt;
      e_rdy = !m_pend || (e_rsp && rsp_ready_i);
      chk("req_ready", req_ready_o, e_rdy);
      chk("out_req", out_req_o, e_req);
      chk("rsp_valid", rsp_valid_o, e_rsp);
      if (e_req) begin
        pack_exp(m_addr, m_amo, m_wen, m_wdata, m_swap, m_be, e_add, e_wen, e_wd, e_be);
        chk("out_add", out_add_o, e_add);
        chk("out_amo", out_amo_o, m_amo);
        chk("out_wen", out_wen_o, e_wen);
        chk("out_wdata", out_wdata_o, e_wd);
        chk("out_be", out_be_o, e_be);
      end
      if (e_rsp) begin
        chk("rsp_rdata", rsp_rdata_o, m_rdata);
        chk("rsp_err", rsp_err_o, m_err);
      end
      if (e_rsp && rsp_ready_i) begin
        m_pend = 0;
        n_rsp++;
      end
      if (e_req && in_gnt_i) begin
        m_gnt  = 1;
        m_gcyc = cyc;
      end
      if (req_valid_i && e_rdy) begin
        m_pend = 1; m_gnt = 0;
        m_addr = req_addr_i; m_amo = req_amo_i; m_wen = req_wen_i;
        m_wdata = req_wdata_i; m_swap = req_swap_i; m_be = req_be_i;
        m_err = illegal_exp(req_amo_i, req_addr_i);
        m_rdata = 32'h0;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic [34:0] a, input logic [3:0] amo, input logic wen,
                           input logic [31:0] wd, input logic [31:0] sw, input logic [3:0] be);
    req_valid_i = 1'b1;
    req_addr_i = a; req_amo_i = amo; req_wen_i = wen;
    req_wdata_i = wd; req_swap_i = sw; req_be_i = be;
  endtask

  initial begin
    int reqcnt;
    repeat (3) tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("reset_ready", req_ready_o, 1);
    chk("reset_rsp_valid", rsp_valid_o, 0);
    tick();

    // Load from the upper half of a 64-bit word.
    in_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
    in_gnt_i = 1'b1; rsp_ready_i = 1'b1;
    drive_req(35'h0C, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk_i); chk("ld_ready", req_ready_o, 1);
    tick(); req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("ld_req", out_req_o, 1); chk("ld_add", out_add_o, 1); chk("ld_be", out_be_o, 8'hF0);
    tick(); @(negedge clk_i); chk("ld_c2_valid", rsp_valid_o, 0);
    tick(); @(negedge clk_i);
    chk("ld_c3_valid", rsp_valid_o, 1); chk("ld_rdata", rsp_rdata_o, 32'hAAAA_BBBB);
    tick();

    // AMOAdd with the grant withheld for three cycles.
    in_gnt_i = 1'b0;
    drive_req(35'h00, 4'h2, 1'b1, 32'h5, 32'h0, 4'h0);
    @(negedge clk_i); chk("add_ready", req_ready_o, 1);
    tick(); req_valid_i = 1'b0;
    reqcnt = 0;
    for (int c = 1; c <= 6; c++) begin
      in_gnt_i = (c == 4);
      @(negedge clk_i);
      if (out_req_o) reqcnt++;
      if (c == 1) begin
        chk("add_be", out_be_o, 8'h0F); chk("add_wen", out_wen_o, 0);
        chk("add_wdata", out_wdata_o, 64'h5); chk("add_amo", out_amo_o, 4'h2);
      end
      chk("add_rsp_valid", rsp_valid_o, (c == 6));
      tick();
    end
    chk("add_req_cycles", reqcnt, 4);

    // CAS on the lower half.
    in_gnt_i = 1'b1;
    drive_req(35'h08, 4'hA, 1'b0, 32'h10, 32'h20, 4'h0);
    tick(); req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("cas_wdata", out_wdata_o, 64'h0000_0020_0000_0010);
    chk("cas_be", out_be_o, 8'h0F); chk("cas_amo", out_amo_o, 4'hA); chk("cas_add", out_add_o, 1);
    tick(); tick(); @(negedge clk_i); chk("cas_rsp", rsp_valid_o, 1);
    tick();

    // Response stalled while the next request waits, then accepted in the handshake cycle.
    rsp_ready_i = 1'b0;
    in_rdata_i = 64'h1111_2222_3333_4444;
    drive_req(35'h10, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick(); req_valid_i = 1'b0;
    tick(); drive_req(35'h14, 4'h0, 1'b1, 32'h0000_DEAD, 32'h0, 4'h3);
    tick();
    for (int k = 0; k < 5; k++) begin
      in_rdata_i = {$urandom, $urandom};
      @(negedge clk_i);
      chk("stall_valid", rsp_valid_o, 1); chk("stall_rdata", rsp_rdata_o, 32'h3333_4444);
      chk("stall_ready", req_ready_o, 0);
      tick();
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i); chk("hs_ready", req_ready_o, 1);
    tick(); req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("st_req", out_req_o, 1); chk("st_add", out_add_o, 2); chk("st_be", out_be_o, 8'h30);
    chk("st_wen", out_wen_o, 1); chk("st_wdata", out_wdata_o, 64'h0000_DEAD_0000_0000);
    tick(); tick(); @(negedge clk_i); chk("st_rdata", rsp_rdata_o, 0);
    tick();

    // Reserved opcode 0xC.
    in_rdata_i = 64'h5555_6666_7777_8888;
    drive_req(35'h00, 4'hC, 1'b0, 32'h1, 32'h0, 4'h0);
    tick(); req_valid_i = 1'b0;
    @(negedge clk_i);
`ifdef AMO_INITIATOR_CHECK_EN
    chk("chk_no_req", out_req_o, 0); chk("chk_rsp_valid", rsp_valid_o, 1);
    chk("chk_err", rsp_err_o, 1); chk("chk_rdata", rsp_rdata_o, 0);
    tick();
`else
    chk("fwd_req", out_req_o, 1); chk("fwd_amo", out_amo_o, 4'hC);
    tick(); tick(); @(negedge clk_i); chk("fwd_err", rsp_err_o, 0);
    tick();
`endif

    // Reset while waiting for read data.
    drive_req(35'h00, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick(); req_valid_i = 1'b0;
    tick(); #1 rst_ni = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_valid", rsp_valid_o, 0); chk("mid_rst_rdata", rsp_rdata_o, 0);
    tick(); rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); chk("post_rst_valid", rsp_valid_o, 0); chk("post_rst_req", out_req_o, 0);
      tick();
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      req_valid_i = ($urandom_range(0, 2) != 0);
      req_addr_i  = 35'($urandom_range(0, 255));
      req_amo_i   = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
      req_wen_i   = 1'($urandom_range(0, 1));
      req_wdata_i = $urandom;
      req_swap_i  = $urandom;
      req_be_i    = 4'($urandom_range(0, 15));
      in_gnt_i    = ($urandom_range(0, 3) != 0);
      rsp_ready_i = ($urandom_range(0, 2) != 0);
      in_rdata_i  = {$urandom, $urandom};
      tick();
    end
    req_valid_i = 1'b0; in_gnt_i = 1'b1; rsp_ready_i = 1'b1;
    repeat (10) tick();
    chk("rsp_count_min", (n_rsp > 100), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
